// File: rtl/toaplan2_prog_loader.sv
// Header-driven ROM download router: parses the region table from the download header and
// packs data bytes into 16-bit SDRAM words. The words are queued against PROG_RDY.
module toaplan2_prog_loader #(
  parameter int REGIONS = 4,
  parameter int SDRAMW  = 22,
  parameter int QDEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [25:0]       IOCTL_ADDR,
  input  logic [7:0]        IOCTL_DOUT,
  input  logic              IOCTL_WR,
  input  logic              IOCTL_RAM,
  input  logic              DOWNLOADING,
  input  logic              PROG_RDY,
  output logic [SDRAMW-1:0] PROG_ADDR,
  output logic [15:0]       PROG_DATA,
  output logic [1:0]        PROG_MASK,
  output logic [1:0]        PROG_BA,
  output logic              PROG_WE,
  output logic              DWNLD_BUSY,
  output logic [7:0]        GAME,
  output logic              OVERFLOW,
  output logic              LOAD_DONE
);
  localparam int HDR_LEN = 1 + 4 * REGIONS;
  localparam int QAW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW      = QAW + 1;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_FLUSH, S_DONE} state_t;
  typedef struct packed {
    logic [SDRAMW-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        mask;
    logic [1:0]        ba;
  } qent_t;

  state_t            state_q, state_d;
  logic              dl_q;
  logic [7:0]        game_q, game_d;
  logic [15:0]       len_q  [REGIONS];
  logic [15:0]       len_d  [REGIONS];
  logic [1:0]        bank_q [REGIONS];
  logic [1:0]        bank_d [REGIONS];
  logic [7:0]        offs_q [REGIONS];
  logic [7:0]        offs_d [REGIONS];
  logic [3:0]        r_q, r_d;
  logic [25:0]       rc_q, rc_d;
  logic              hold_vld_q, hold_vld_d;
  logic [7:0]        hold_byte_q, hold_byte_d;
  logic [SDRAMW-1:0] hold_addr_q, hold_addr_d;
  logic [1:0]        hold_ba_q, hold_ba_d;
  qent_t             mem_q [QDEPTH];
  qent_t             mem_d [QDEPTH];
  logic [QAW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              byte_wr, dl_rise, pop, full, push, push_ok;
  qent_t             push_ent;
  logic              eff_ok, more_ok;
  int                eff_i;
  logic [15:0]       eff_len;
  logic [1:0]        eff_bank;
  logic [7:0]        eff_offs;
  logic [25:0]       last_rc;
  logic [31:0]       waddr_w;
  logic [SDRAMW-1:0] cur_waddr;

  always_comb begin
    byte_wr = IOCTL_WR & ~IOCTL_RAM;
    dl_rise = DOWNLOADING & ~dl_q;

    // First non-empty region at or after r_q; empty regions are skipped here.
    eff_ok = 1'b0; eff_i = 0; eff_len = '0; eff_bank = '0; eff_offs = '0;
    for (int i = 0; i < REGIONS; i++) begin
      if (!eff_ok && i >= int'(r_q) && len_q[i] != 16'd0) begin
        eff_ok = 1'b1; eff_i = i;
        eff_len = len_q[i]; eff_bank = bank_q[i]; eff_offs = offs_q[i];
      end
    end
    more_ok = 1'b0;
    for (int i = 0; i < REGIONS; i++)
      if (eff_ok && i > eff_i && len_q[i] != 16'd0) more_ok = 1'b1;
    last_rc   = {eff_len, 10'd0} - 26'd1;
    waddr_w   = 32'({eff_offs, 15'd0}) + 32'(rc_q[25:1]);
    cur_waddr = waddr_w[SDRAMW-1:0];

    state_d = state_q; game_d = game_q;
    len_d = len_q; bank_d = bank_q; offs_d = offs_q;
    r_d = r_q; rc_d = rc_q;
    hold_vld_d = hold_vld_q; hold_byte_d = hold_byte_q;
    hold_addr_d = hold_addr_q; hold_ba_d = hold_ba_q;
    push = 1'b0; push_ent = '0; done_d = 1'b0;

    case (state_q)
      S_IDLE: if (dl_rise) begin
        state_d = S_HEADER; r_d = '0; rc_d = '0; hold_vld_d = 1'b0;
      end
      S_HEADER: begin
        if (!DOWNLOADING) state_d = S_IDLE;
        else if (byte_wr) begin
          if (IOCTL_ADDR == 26'd0) game_d = IOCTL_DOUT;
          for (int i = 0; i < REGIONS; i++) begin
            if (IOCTL_ADDR == 26'(1 + 4*i)) len_d[i][7:0]  = IOCTL_DOUT;
            if (IOCTL_ADDR == 26'(2 + 4*i)) len_d[i][15:8] = IOCTL_DOUT;
            if (IOCTL_ADDR == 26'(3 + 4*i)) bank_d[i]      = IOCTL_DOUT[1:0];
            if (IOCTL_ADDR == 26'(4 + 4*i)) offs_d[i]      = IOCTL_DOUT;
          end
          if (IOCTL_ADDR == 26'(HDR_LEN - 1)) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (byte_wr && eff_ok) begin
          if (!rc_q[0]) begin
            hold_vld_d = 1'b1; hold_byte_d = IOCTL_DOUT;
            hold_addr_d = cur_waddr; hold_ba_d = eff_bank;
          end else begin
            push = 1'b1;
            push_ent = '{addr: cur_waddr, data: {IOCTL_DOUT, hold_byte_q}, mask: 2'b00, ba: eff_bank};
            hold_vld_d = 1'b0;
          end
          if (rc_q == last_rc) begin
            rc_d = '0; r_d = 4'(eff_i + 1);
            if (!more_ok) state_d = S_FLUSH;
          end else begin
            rc_d = rc_q + 26'd1; r_d = 4'(eff_i);
          end
        end
        if (!DOWNLOADING || !eff_ok) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // A leftover even byte is written to both halves with the high byte masked off.
        if (hold_vld_q) begin
          push = 1'b1;
          push_ent = '{addr: hold_addr_q, data: {hold_byte_q, hold_byte_q}, mask: 2'b10, ba: hold_ba_q};
          hold_vld_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE; done_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pop  = PROG_RDY && (cnt_q != '0);
    full = (cnt_q == CW'(QDEPTH));
    mem_d = mem_q; wp_d = wp_q; rp_d = rp_q;
    ovf_d = dl_rise ? 1'b0 : ovf_q;
    push_ok = push && (!full || pop);
    if (push_ok) begin
      mem_d[wp_q] = push_ent;
      wp_d = wp_q + 1'b1;
    end else if (push) ovf_d = 1'b1;
    if (pop) rp_d = rp_q + 1'b1;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE; dl_q <= 1'b0; game_q <= '0;
      for (int i = 0; i < REGIONS; i++) begin
        len_q[i] <= '0; bank_q[i] <= '0; offs_q[i] <= '0;
      end
      r_q <= '0; rc_q <= '0;
      hold_vld_q <= 1'b0; hold_byte_q <= '0; hold_addr_q <= '0; hold_ba_q <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0; rp_q <= '0; cnt_q <= '0;
      ovf_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; dl_q <= DOWNLOADING; game_q <= game_d;
      len_q <= len_d; bank_q <= bank_d; offs_q <= offs_d;
      r_q <= r_d; rc_q <= rc_d;
      hold_vld_q <= hold_vld_d; hold_byte_q <= hold_byte_d;
      hold_addr_q <= hold_addr_d; hold_ba_q <= hold_ba_d;
      mem_q <= mem_d; wp_q <= wp_d; rp_q <= rp_d; cnt_q <= cnt_d;
      ovf_q <= ovf_d; done_q <= done_d;
    end
  end

  assign PROG_WE    = (cnt_q != '0);
  assign PROG_ADDR  = mem_q[rp_q].addr;
  assign PROG_DATA  = mem_q[rp_q].data;
  assign PROG_MASK  = mem_q[rp_q].mask;
  assign PROG_BA    = mem_q[rp_q].ba;
  assign GAME       = game_q;
  assign OVERFLOW   = ovf_q;
  assign LOAD_DONE  = done_q;
  assign DWNLD_BUSY = DOWNLOADING | (state_q != S_IDLE && state_q != S_DONE);
endmodule

// File: tb/tb_toaplan2_prog_loader.sv
// Directed bench for toaplan2_prog_loader: header parsing, packing, queueing, flush and reset.
module tb_toaplan2_prog_loader;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic [25:0] IOCTL_ADDR = '0;
  logic [7:0]  IOCTL_DOUT = '0;
  logic        IOCTL_WR = 1'b0, IOCTL_RAM = 1'b0, DOWNLOADING = 1'b0, PROG_RDY = 1'b1;
  logic [21:0] PROG_ADDR;
  logic [15:0] PROG_DATA;
  logic [1:0]  PROG_MASK, PROG_BA;
  logic        PROG_WE, DWNLD_BUSY, OVERFLOW, LOAD_DONE;
  logic [7:0]  GAME;

  toaplan2_prog_loader dut (
    .CLK(CLK), .RESET(RESET), .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DOUT(IOCTL_DOUT),
    .IOCTL_WR(IOCTL_WR), .IOCTL_RAM(IOCTL_RAM), .DOWNLOADING(DOWNLOADING),
    .PROG_RDY(PROG_RDY), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
    .PROG_MASK(PROG_MASK), .PROG_BA(PROG_BA), .PROG_WE(PROG_WE),
    .DWNLD_BUSY(DWNLD_BUSY), .GAME(GAME), .OVERFLOW(OVERFLOW), .LOAD_DONE(LOAD_DONE));

  always #5 CLK = ~CLK;

  typedef struct { logic [21:0] a; logic [15:0] d; logic [1:0] m; logic [1:0] b; } wr_t;
  wr_t cap[$];
  int ncmp = 0, nerr = 0;
  logic [15:0] h_len [4];
  logic [1:0]  h_bank[4];
  logic [7:0]  h_offs[4];
  logic [25:0] daddr;

  // Record every accepted write (PROG_RDY only changes just after posedge).
  always @(negedge CLK)
    if (!RESET && PROG_WE && PROG_RDY)
      cap.push_back('{a: PROG_ADDR, d: PROG_DATA, m: PROG_MASK, b: PROG_BA});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [25:0] a, input logic [7:0] d);
    @(negedge CLK); IOCTL_ADDR = a; IOCTL_DOUT = d; IOCTL_WR = 1'b1;
    @(negedge CLK); IOCTL_WR = 1'b0;
  endtask

  task automatic sdata(input logic [7:0] d);
    send(daddr, d); daddr = daddr + 26'd1;
  endtask

  task automatic set_rdy(input logic v);
    @(posedge CLK); #1 PROG_RDY = v;
  endtask

  task automatic start_dl(input logic [7:0] game);
    @(negedge CLK); DOWNLOADING = 1'b1;
    @(negedge CLK);
    send(26'd0, game);
    for (int r = 0; r < 4; r++) begin
      send(26'(1 + 4*r), h_len[r][7:0]);
      send(26'(2 + 4*r), h_len[r][15:8]);
      send(26'(3 + 4*r), {6'd0, h_bank[r]});
      send(26'(4 + 4*r), h_offs[r]);
    end
    daddr = 26'd17;
  endtask

  task automatic end_dl(input string tag);
    logic seen;
    seen = 1'b0;
    @(negedge CLK); DOWNLOADING = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (LOAD_DONE) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic set_hdr(input int r, input logic [15:0] l, input logic [1:0] b, input logic [7:0] o);
    h_len[r] = l; h_bank[r] = b; h_offs[r] = o;
  endtask

  initial begin
    for (int r = 0; r < 4; r++) set_hdr(r, 16'd0, 2'd0, 8'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_we", {31'd0, PROG_WE}, 32'd0);
    check("rst_game", {24'd0, GAME}, 32'd0);
    check("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    check("rst_done", {31'd0, LOAD_DONE}, 32'd0);
    check("rst_busy", {31'd0, DWNLD_BUSY}, 32'd0);
    check("rst_addr", {10'd0, PROG_ADDR}, 32'd0);

    // T1: two regions, four data bytes
    set_hdr(0, 16'h200, 2'd0, 8'd0); set_hdr(1, 16'h800, 2'd1, 8'd0);
    start_dl(8'd2);
    check("t1_game", {24'd0, GAME}, 32'd2);
    check("t1_busy", {31'd0, DWNLD_BUSY}, 32'd1);
    sdata(8'hAA); sdata(8'hBB);
    check("t1_lat_we", {31'd0, PROG_WE}, 32'd1);
    check("t1_lat_data", {16'd0, PROG_DATA}, 32'hBBAA);
    sdata(8'hCC); sdata(8'hDD);
    repeat (3) @(negedge CLK);
    check("t1_nwr", cap.size(), 32'd2);
    if (cap.size() == 2) begin
      check("t1_w0", {cap[0].a, cap[0].m, cap[0].b}, {22'd0, 2'b00, 2'd0});
      check("t1_w0d", {16'd0, cap[0].d}, 32'hBBAA);
      check("t1_w1", {cap[1].a, cap[1].m, cap[1].b}, {22'd1, 2'b00, 2'd0});
      check("t1_w1d", {16'd0, cap[1].d}, 32'hDDCC);
    end
    end_dl("t1_done");
    check("t1_idle_busy", {31'd0, DWNLD_BUSY}, 32'd0);
    check("t1_nwr_end", cap.size(), 32'd2);
    cap.delete();

    // T2: region boundary to bank1 offs2
    set_hdr(0, 16'd1, 2'd0, 8'd0); set_hdr(1, 16'd1, 2'd1, 8'd2);
    start_dl(8'd3);
    for (int i = 0; i < 1024; i++) sdata(8'(i));
    repeat (2) @(negedge CLK);
    check("t2_r0_nwr", cap.size(), 32'd512);
    if (cap.size() == 512) begin
      check("t2_first", {cap[0].a, cap[0].d}, {22'd0, 16'h0100});
      check("t2_last", {cap[511].a, cap[511].d}, {22'd511, 16'hFFFE});
    end
    sdata(8'h77); sdata(8'h88);
    repeat (2) @(negedge CLK);
    check("t2_nwr", cap.size(), 32'd513);
    if (cap.size() == 513) begin
      check("t2_r1_addr", {10'd0, cap[512].a}, 32'h10000);
      check("t2_r1_ba", {30'd0, cap[512].b}, 32'd1);
      check("t2_r1_data", {16'd0, cap[512].d}, 32'h8877);
    end
    end_dl("t2_done");
    cap.delete();

    // T3: stalled SDRAM, third word overflows
    set_hdr(0, 16'd1, 2'd2, 8'd1); set_hdr(1, 16'd0, 2'd0, 8'd0);
    start_dl(8'd4);
    set_rdy(1'b0);
    for (int i = 1; i <= 6; i++) sdata(8'(i));
    check("t3_ovf", {31'd0, OVERFLOW}, 32'd1);
    check("t3_head", {PROG_WE, 7'd0, PROG_BA, PROG_ADDR}, {1'b1, 7'd0, 2'd2, 22'h8000});
    set_rdy(1'b1);
    repeat (4) @(negedge CLK);
    check("t3_nwr", cap.size(), 32'd2);
    if (cap.size() == 2) begin
      check("t3_w0", {cap[0].a, cap[0].d}, {22'h8000, 16'h0201});
      check("t3_w1", {cap[1].a, cap[1].d}, {22'h8001, 16'h0403});
    end
    end_dl("t3_done");
    check("t3_ovf_sticky", {31'd0, OVERFLOW}, 32'd1);
    cap.delete();

    // T4: odd byte count, truncated download
    set_hdr(0, 16'd1, 2'd3, 8'd0);
    start_dl(8'd5);
    check("t4_ovf_clr", {31'd0, OVERFLOW}, 32'd0);
    sdata(8'h11); sdata(8'h22); sdata(8'h33);
    end_dl("t4_done");
    check("t4_nwr", cap.size(), 32'd2);
    if (cap.size() == 2) begin
      check("t4_w0", {cap[0].a, cap[0].d, cap[0].m, cap[0].b}, {22'd0, 16'h2211, 2'b00, 2'd3});
      check("t4_w1", {cap[1].a, cap[1].d, cap[1].m, cap[1].b}, {22'd1, 16'h3333, 2'b10, 2'd3});
    end
    cap.delete();

    // T6: empty region skipped, NVRAM bytes ignored
    set_hdr(0, 16'd1, 2'd0, 8'd0); set_hdr(1, 16'd0, 2'd1, 8'd1); set_hdr(2, 16'd1, 2'd2, 8'd3);
    start_dl(8'd6);
    for (int i = 0; i < 1024; i++) sdata(8'(i));
    IOCTL_RAM = 1'b1;
    sdata(8'hE1); sdata(8'hE2);
    IOCTL_RAM = 1'b0;
    repeat (2) @(negedge CLK);
    check("t6_ram_nwr", cap.size(), 32'd512);
    sdata(8'h5A); sdata(8'hA5);
    repeat (2) @(negedge CLK);
    check("t6_nwr", cap.size(), 32'd513);
    if (cap.size() == 513) begin
      check("t6_r2", {cap[512].a, cap[512].d, cap[512].m, cap[512].b}, {22'h18000, 16'hA55A, 2'b00, 2'd2});
    end
    end_dl("t6_done");
    cap.delete();

    // T5: reset in the middle of DATA with a pending write
    set_hdr(0, 16'd1, 2'd1, 8'd0); set_hdr(2, 16'd0, 2'd0, 8'd0);
    start_dl(8'd7);
    set_rdy(1'b0);
    sdata(8'h01); sdata(8'h02);
    check("t5_we_pre", {31'd0, PROG_WE}, 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    check("t5_we", {31'd0, PROG_WE}, 32'd0);
    check("t5_game", {24'd0, GAME}, 32'd0);
    check("t5_busy_hi", {31'd0, DWNLD_BUSY}, 32'd1);
    RESET = 1'b0; DOWNLOADING = 1'b0;
    @(negedge CLK);
    check("t5_busy_lo", {31'd0, DWNLD_BUSY}, 32'd0);
    check("t5_done", {31'd0, LOAD_DONE}, 32'd0);
    set_rdy(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
